// File: rtl/max_unpool2d_stream.sv
// max_unpool2d_stream: buffers one pooled frame with argmax indices, then streams the STRIDE-upsampled frame in raster order
// Ports: clk/rst (sync, active-high); in_data/in_idx/in_valid/in_ready pooled input beats;
//        out_data/out_valid/out_ready/out_last unpooled output beats; busy high while emitting.
// Option: define UNPOOL_NEAREST_EN for nearest-neighbour upsampling (in_idx ignored).
module max_unpool2d_stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int POOL_WIDTH  = 2,
  parameter int POOL_HEIGHT = 2,
  parameter int CHANNELS    = 2,
  parameter int STRIDE      = 2,
  localparam int IDX_W = STRIDE * STRIDE > 1 ? $clog2(STRIDE * STRIDE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);
  localparam int OUT_W = POOL_WIDTH * STRIDE;
  localparam int OUT_H = POOL_HEIGHT * STRIDE;
  localparam int N     = POOL_WIDTH * POOL_HEIGHT * CHANNELS;
  localparam int AW    = N > 1 ? $clog2(N) : 1;
  localparam int CW    = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int YW    = OUT_H > 1 ? $clog2(OUT_H) : 1;
  localparam int XW    = OUT_W > 1 ? $clog2(OUT_W) : 1;

  typedef enum logic {LOAD, EMIT} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_val [N];
  logic [AW-1:0]         r_wr;
  logic [CW-1:0]         r_c;
  logic [YW-1:0]         r_y;
  logic [XW-1:0]         r_x;
  logic                  r_in_ready, r_out_valid, r_out_last, r_busy;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic                  w_wr_fire, w_wr_last, w_out_fire, w_out_end;
  logic                  w_x_wrap, w_y_wrap, w_last, w_fwd;
  logic [CW-1:0]         w_nc;
  logic [YW-1:0]         w_ny;
  logic [XW-1:0]         w_nx;
  logic [AW-1:0]         w_src;
  logic [DATA_WIDTH-1:0] w_val, w_data;

  assign w_wr_fire  = r_in_ready && in_valid;
  assign w_wr_last  = w_wr_fire && r_wr == AW'(N - 1);
  assign w_out_fire = r_out_valid && out_ready;
  assign w_out_end  = w_out_fire && r_out_last;
  assign w_x_wrap   = r_x == XW'(OUT_W - 1);
  assign w_y_wrap   = r_y == YW'(OUT_H - 1);

  // Coordinates of the beat to present next: origin when a frame completes loading, else raster advance.
  assign w_nx = w_wr_last || w_x_wrap ? '0 : r_x + 1'b1;
  assign w_ny = w_wr_last ? '0 : w_x_wrap ? (w_y_wrap ? '0 : r_y + 1'b1) : r_y;
  assign w_nc = w_wr_last ? '0 : w_x_wrap && w_y_wrap ? r_c + 1'b1 : r_c;

  assign w_src  = AW'((int'(w_nc) * POOL_HEIGHT + int'(w_ny) / STRIDE) * POOL_WIDTH + int'(w_nx) / STRIDE);
  // The first output beat is computed on the same edge that writes the last entry, so forward it.
  assign w_fwd  = w_wr_fire && r_wr == w_src;
  assign w_val  = w_fwd ? in_data : r_val[w_src];
  assign w_last = w_nc == CW'(CHANNELS - 1) && w_ny == YW'(OUT_H - 1) && w_nx == XW'(OUT_W - 1);

`ifdef UNPOOL_NEAREST_EN
  logic w_unused;
  assign w_unused = ^in_idx;
  assign w_data   = w_val;
`else
  logic [IDX_W-1:0] r_idx [N];
  logic [IDX_W-1:0] w_idx;
  int               w_p;
  assign w_idx  = w_fwd ? in_idx : r_idx[w_src];
  assign w_p    = (int'(w_ny) % STRIDE) * STRIDE + int'(w_nx) % STRIDE;
  // Indices outside the window never equal w_p, so such windows emit all zeros.
  assign w_data = int'(w_idx) == w_p ? w_val : '0;

  always_ff @(posedge clk)
    if (!rst && w_wr_fire) r_idx[r_wr] <= in_idx;
`endif

  always_ff @(posedge clk)
    if (!rst && w_wr_fire) r_val[r_wr] <= in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_wr        <= '0;
      r_c         <= '0;
      r_y         <= '0;
      r_x         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else if (r_state == LOAD) begin
      if (w_wr_last) begin
        r_state     <= EMIT;
        r_wr        <= '0;
        r_c         <= w_nc;
        r_y         <= w_ny;
        r_x         <= w_nx;
        r_in_ready  <= 1'b0;
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_last  <= w_last;
        r_busy      <= 1'b1;
      end else if (w_wr_fire) begin
        r_wr <= r_wr + 1'b1;
      end
    end else if (w_out_end) begin
      r_state     <= LOAD;
      r_c         <= '0;
      r_y         <= '0;
      r_x         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_out_fire) begin
      r_c        <= w_nc;
      r_y        <= w_ny;
      r_x        <= w_nx;
      r_out_data <= w_data;
      r_out_last <= w_last;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
endmodule

// File: tb/tb_max_unpool2d_stream.sv
// tb_max_unpool2d_stream: directed self-checking bench for max_unpool2d_stream with default parameters
module tb_max_unpool2d_stream;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic [1:0] in_idx = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fv [8];
  logic [1:0] fi [8];
  logic [7:0] ev [32];

  always #5 clk = ~clk;

  max_unpool2d_stream dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_idx(in_idx), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame_a();
    fv = '{8'd6, 8'd8, 8'd14, 8'd16, 8'd22, 8'd24, 8'd30, 8'd32};
    fi = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
`ifdef UNPOOL_NEAREST_EN
    ev = '{6,6,8,8, 6,6,8,8, 14,14,16,16, 14,14,16,16,
           22,22,24,24, 22,22,24,24, 30,30,32,32, 30,30,32,32};
`else
    ev = '{0,0,0,0, 0,6,0,8, 0,0,0,0, 0,14,0,16,
           22,0,0,24, 0,0,0,0, 0,0,0,0, 30,0,0,32};
`endif
  endtask

  // Drive the 8 input beats at negedges; returns at the negedge where the first output must be visible.
  task automatic load_frame();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("load_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = fv[i];
      in_idx   = fi[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("latency_out_valid", out_valid, 1);
    check("emit_busy", busy, 1);
  endtask

  // Accept nb beats; tog toggles out_ready every cycle; junk keeps in_valid=1 with 99 during EMIT.
  task automatic collect(input int nb, input bit tog, input bit junk);
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [7:0] held = '0;
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'd99;
      in_idx   = 2'd0;
    end
    while (k < nb && cyc < 200) begin
      out_ready = tog ? cyc[0] : 1'b1;
      check("emit_in_ready", in_ready, 0);
      if (stalled) check("stall_hold", out_data, held);
      if (out_valid && out_ready) begin
        check($sformatf("beat%0d_data", k), out_data, ev[k]);
        check($sformatf("beat%0d_last", k), out_last, k == 31);
        if (k == 31) in_valid = 1'b0;
        k++;
        stalled = 1'b0;
      end else begin
        check("emit_valid", out_valid, 1);
        held = out_data;
        stalled = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    if (k < nb) check("timeout_beats", k, nb);
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    // Reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset");
    check("reset_out_data", out_data, 0);

    // Frame unpool with sustained out_ready
    frame_a();
    load_frame();
    collect(32, 1'b0, 1'b0);
    check_idle("after_frame");

    // Backpressure: out_ready toggles every cycle
    load_frame();
    collect(32, 1'b1, 1'b0);
    check_idle("after_bp");

    // Input beats offered during EMIT must be ignored
    load_frame();
    collect(32, 1'b0, 1'b1);
    check_idle("after_junk");
    load_frame();
    collect(32, 1'b0, 1'b0);
    check_idle("next_frame");

    // Reset after 10 beats, with a handshake pending on the reset edge
    load_frame();
    collect(10, 1'b0, 1'b0);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    check_idle("mid_emit_reset");

    // Fresh frame: all ones with idx 0 -> ones at even (x,y) only
    for (int i = 0; i < 8; i++) begin
      fv[i] = 8'd1;
      fi[i] = 2'd0;
    end
    for (int k = 0; k < 32; k++) begin
`ifdef UNPOOL_NEAREST_EN
      ev[k] = 8'd1;
`else
      ev[k] = (((k / 4) % 2) == 0 && (k % 2) == 0) ? 8'd1 : 8'd0;
`endif
    end
    load_frame();
    collect(32, 1'b0, 1'b0);
    check_idle("after_fresh");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
